// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, request latch layout.
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam int MEM_BYTES_DEF = 1024;

    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction
endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: little-endian extract/extend for loads, lane merge for sub-word stores.
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [31:0] byte_word;
    logic [31:0] half_word;
    logic [31:0] mask;

    assign byte_shift = {offset, 3'b000};
    assign half_shift = {offset[1], 4'b0000};
    assign byte_word  = word >> byte_shift;
    assign half_word  = word >> half_shift;

    always_comb begin
        load_data  = word;
        merge_data = wdata;
        mask       = '0;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{~is_unsigned & byte_word[7]}}, byte_word[7:0]};
                mask       = 32'h0000_00FF << byte_shift;
                merge_data = (word & ~mask) | ((wdata & 32'h0000_00FF) << byte_shift);
            end
            SZ_HALF: begin
                load_data  = {{16{~is_unsigned & half_word[15]}}, half_word[15:0]};
                mask       = 32'h0000_FFFF << half_shift;
                merge_data = (word & ~mask) | ((wdata & 32'h0000_FFFF) << half_shift);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit; sub-word stores are read-modify-write on whole memory words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);
    state_t      state;
    req_t        req;
    logic [31:0] wword;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] end_addr;

    // 33-bit sum so an address near 2^32 cannot wrap into range
    assign end_addr     = {1'b0, req_addr} + {30'd0, size_bytes(req_size)};
    assign illegal      = (req_size == 2'b11);
    assign misaligned   = ((req_size == SZ_HALF) && req_addr[0]) ||
                          ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign out_of_range = end_addr > 33'(MEM_BYTES);

    // Memory strobes are gated by rst so an abandoned write never lands on the reset edge
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign mem_read   = (state == RD) && !rst;
    assign mem_write  = (state == WR) && !rst;
    assign mem_addr   = {req.addr[31:2], 2'b00};
    assign mem_wd     = ((state == WR) && !rst) ? wword : '0;

    lsu_byte_lane u_lane (
        .word        (mem_rd),
        .offset      (req.addr[1:0]),
        .size        (req.size),
        .is_unsigned (req.is_unsigned),
        .wdata       (req.wdata),
        .load_data   (lane_load),
        .merge_data  (lane_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req        <= '0;
            wword      <= '0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    req <= '{write: req_write, size: req_size, is_unsigned: req_unsigned,
                             addr: req_addr, wdata: req_wdata};
                    if (illegal || misaligned || out_of_range) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                        state      <= RESP;
                    end else if (req_write && req_size == SZ_WORD) begin
                        wword <= req_wdata;
                        state <= WR;
                    end else begin
                        state <= RD;
                    end
                end
                RD:  state <= CAP;
                CAP: begin
                    if (req.write) begin
                        wword <= lane_merge;
                        state <= WR;
                    end else begin
                        resp_err   <= 1'b0;
                        resp_rdata <= lane_load;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
